max_pool_feeder: RTL and testbench
==================================

# max_pool_feeder

Sequencer that drives the float16 max-pool compare unit (`MaxPoolUnitFloat16`) from a feature-map memory. For each K×K pooling window it:
- reads the window's samples in row-major order;
- streams them on `cmp_data` with `data_num` = K·K;
- waits for `result_ready` and captures `max_pool_result`;
- writes the result to the output map.

It sits between the feature-map buffer and the pooling unit. It is the producer/consumer end of the unit's `cmp_data` / `result_ready` interface.

## Interface
Parameters:
- `DATA_WIDTH`, 16, sample width (IEEE half)
- `CLK_NUM_WIDTH`, 8, width of `data_num`
- `ADDR_WIDTH`, 12, memory address width
- `DIM_WIDTH`, 8, width of map dimensions, kernel and stride

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (0: reset; 1: run)
- `start`  in  1  one-cycle job request, honoured only in IDLE
- `fm_width`, `fm_height`  in  DIM_WIDTH  input map W, H
- `pool_size`  in  DIM_WIDTH  K
- `pool_stride`  in  DIM_WIDTH  S
- `in_base`, `out_base`  in  ADDR_WIDTH  map base addresses
- `rd_en`  out  1  input-memory read strobe
- `rd_addr`  out  ADDR_WIDTH  read address
- `rd_data`  in  DATA_WIDTH  read data, valid 1 cycle after `rd_en`
- `cmp_data`  out  DATA_WIDTH  sample to pool unit
- `data_num`  out  CLK_NUM_WIDTH  window length K·K
- `result_ready`  in  1  pool unit result valid
- `max_pool_result`  in  DATA_WIDTH  pool unit result
- `wr_en`  out  1  output-memory write strobe
- `wr_addr`  out  ADDR_WIDTH  write address
- `wr_data`  out  DATA_WIDTH  write data
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle job-complete pulse
- `cfg_err`  out  1  sticky config error, cleared by next accepted `start`

## Operation
- **Config latch.** Config is registered on the accepted `start` and ignored afterwards.
- **Output dimensions.** OW = (W−K)/S+1, OH = (H−K)/S+1, using integer division.
- **Config check.** The config is invalid if K=0, S=0, K>W, K>H, or K·K > 2^CLK_NUM_WIDTH−1. An invalid config sets `cfg_err`, pulses `done` next cycle, and performs no reads or writes.
- **Addressing.**
  - Window (ox,oy) sample (kx,ky) reads address `in_base + (oy·S+ky)·W + (ox·S+kx)`.
  - The result writes to `out_base + oy·OW + ox`.
  - All address arithmetic is modulo 2^ADDR_WIDTH.
- **Window order.** Windows are processed ox-fastest, then oy.
- **`data_num`.** Driven as K·K from the accepted `start` until `done`.

States:
- **IDLE**
  - `busy`=0.
  - `start` with a valid config → FEED.
- **FEED**
  - Issues K·K consecutive reads, one per cycle, with `rd_en`=1.
  - `cmp_data` <= `rd_data` registered, so sample n appears on `cmp_data` 2 cycles after its `rd_en`.
  - After the last read → DRAIN.
- **DRAIN**
  - Waits until the last sample has been on `cmp_data` for 1 cycle.
  - `cmp_data` holds the last sample; it is never changed outside FEED.
  - → WAIT_RES.
- **WAIT_RES**
  - Holds `cmp_data`.
  - On `result_ready`=1, captures `max_pool_result` → WRITE.
- **WRITE**
  - One cycle with `wr_en`=1.
  - If more windows remain → FEED; otherwise → IDLE and pulse `done`.

Boundary conditions:
- **Reset** at any time, mid-job included:
  - all outputs go to 0: `cmp_data`=16'h0000, `data_num`=0, `rd_en`/`wr_en`/`busy`/`done`/`cfg_err`=0;
  - state returns to IDLE;
  - the partial job is discarded and no write completes.
- `start` while `busy` is ignored.
- `result_ready` outside WAIT_RES is ignored.
- The feeder never touches the pool unit's reset.

## Timing
- **Start of job.** `start` at cycle t gives `busy`=1 and the first `rd_en` at t+1.
- **Sample stream.** The first `cmp_data` sample is at t+3. Samples are contiguous for exactly K·K cycles, matching the unit's contract: `data_num` stable with the first sample, then one sample per clock.
- **Result.** The unit delivers `result_ready` `data_num`+2 cycles after the first sample. WRITE follows on the next cycle.
- **Next window.** Its first read is issued in the WRITE cycle's successor.
- **End of job.** `done` is asserted in the cycle after the last WRITE, together with `busy`=0.

## Structure
- Shared package holds `DATA_WIDTH`, `CLK_NUM_WIDTH`, the fp16 constants 16'h3C00 (1.0) and 16'hFC00 (−inf), and the state encoding.
- Natural sub-module: `pool_window_addr_gen`, containing the counters kx/ky/ox/oy and the address computation (read address and write address, last-sample and last-window flags).
- The FSM and data registers stay in the top level.

## Test plan
- **4×4 map, K=2, S=2.** Map holds values 1..16 (16'h3C00 … 16'h4C00) row-major. Expect 4 writes of 6, 8, 14, 16 at `out_base`+0..3, `data_num`=4, then one `done` pulse.
- **3×3 map, K=3, S=1.** Expect `data_num`=9, read addresses `in_base`+0..8 in order, 1 write at `out_base`, first `cmp_data` at `start`+3.
- **Config errors.**
  - 4×4 map, K=5 → `cfg_err`=1, `done` at `start`+1, zero `rd_en`/`wr_en`.
  - S=0 → same response.
- **Result delay.** Delay `result_ready` by 10 extra cycles → `cmp_data` holds the last sample throughout and exactly one write follows.
- **Reset mid-job.** Assert `rst`=0 during FEED of window 2 → all outputs 0 immediately. A new `start` after release restarts at window 0.
- **`start` while busy.** Pulse `start` during a job with a different config → the job completes with the original config and the same write count.

Source files
------------

// File: rtl/max_pool_feeder_pkg.sv
// max_pool_feeder_pkg: shared widths, fp16 constants and FSM encoding for the max-pool feeder
package max_pool_feeder_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int CLK_NUM_WIDTH = 8;
  localparam logic [15:0] FP16_ONE = 16'h3C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FEED = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] WAIT_RES = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
endpackage

// File: rtl/pool_window_addr_gen.sv
// pool_window_addr_gen: window/kernel counters and read/write address generation
module pool_window_addr_gen #(
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  step,
  input  logic                  next_win,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [DIM_WIDTH-1:0]  height,
  input  logic [DIM_WIDTH-1:0]  k,
  input  logic [DIM_WIDTH-1:0]  s,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  last_sample,
  output logic                  last_win
);
  import max_pool_feeder_pkg::*;
  logic [DIM_WIDTH-1:0] kx, ky;
  logic [DIM_WIDTH:0] col_base, row_base;
  logic [ADDR_WIDTH-1:0] row_off, row_addr, win_idx, row_step;
  logic last_col, last_row, kx_end, ky_end;
  assign row_step = ADDR_WIDTH'(s) * ADDR_WIDTH'(width);
  assign kx_end = kx == k - 1'b1;
  assign ky_end = ky == k - 1'b1;
  assign last_sample = kx_end && ky_end;
  assign last_col = (DIM_WIDTH+2)'(col_base) + (DIM_WIDTH+2)'(s) + (DIM_WIDTH+2)'(k) > (DIM_WIDTH+2)'(width);
  assign last_row = (DIM_WIDTH+2)'(row_base) + (DIM_WIDTH+2)'(s) + (DIM_WIDTH+2)'(k) > (DIM_WIDTH+2)'(height);
  assign last_win = last_col && last_row;
  assign rd_addr = in_base + row_addr + row_off + ADDR_WIDTH'(col_base) + ADDR_WIDTH'(kx);
  assign wr_addr = out_base + win_idx;
  // kernel counters wrap after the last sample; window position moves on each write, ox fastest
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      kx <= '0;
      ky <= '0;
      row_off <= '0;
      col_base <= '0;
      row_base <= '0;
      row_addr <= '0;
      win_idx <= '0;
    end else if (init) begin
      kx <= '0;
      ky <= '0;
      row_off <= '0;
      col_base <= '0;
      row_base <= '0;
      row_addr <= '0;
      win_idx <= '0;
    end else begin
      if (step) begin
        kx <= kx_end ? '0 : kx + 1'b1;
        if (kx_end) begin
          ky <= ky_end ? '0 : ky + 1'b1;
          row_off <= ky_end ? '0 : row_off + ADDR_WIDTH'(width);
        end
      end
      if (next_win) begin
        win_idx <= win_idx + 1'b1;
        col_base <= last_col ? '0 : col_base + (DIM_WIDTH+1)'(s);
        if (last_col) begin
          row_base <= row_base + (DIM_WIDTH+1)'(s);
          row_addr <= row_addr + row_step;
        end
      end
    end
endmodule

// File: rtl/max_pool_feeder.sv
// max_pool_feeder: streams K x K windows from a feature map into the fp16 max-pool unit and stores the results
module max_pool_feeder #(
  parameter int DATA_WIDTH = max_pool_feeder_pkg::DATA_WIDTH,
  parameter int CLK_NUM_WIDTH = max_pool_feeder_pkg::CLK_NUM_WIDTH,
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DIM_WIDTH-1:0]     fm_width,
  input  logic [DIM_WIDTH-1:0]     fm_height,
  input  logic [DIM_WIDTH-1:0]     pool_size,
  input  logic [DIM_WIDTH-1:0]     pool_stride,
  input  logic [ADDR_WIDTH-1:0]    in_base,
  input  logic [ADDR_WIDTH-1:0]    out_base,
  output logic                     rd_en,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    cmp_data,
  output logic [CLK_NUM_WIDTH-1:0] data_num,
  input  logic                     result_ready,
  input  logic [DATA_WIDTH-1:0]    max_pool_result,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);
  import max_pool_feeder_pkg::*;
  logic [2:0] state, state_d;
  logic [DIM_WIDTH-1:0] width_q, height_q, k_q, s_q;
  logic [ADDR_WIDTH-1:0] in_base_q, out_base_q;
  logic [2*DIM_WIDTH-1:0] kk;
  logic [DATA_WIDTH-1:0] res_q;
  logic accept, cfg_ok, rd_vld, last_sample, last_win;
  assign kk = pool_size * pool_size;
  assign cfg_ok = pool_size != '0 && pool_stride != '0 && pool_size <= fm_width &&
                  pool_size <= fm_height && (kk >> CLK_NUM_WIDTH) == '0;
  assign accept = start && state == IDLE;
  assign rd_en = state == FEED;
  assign wr_en = state == WRITE;
  assign wr_data = res_q;
  assign busy = state != IDLE;
  // DRAIN lasts until the last read has passed through rd_data into cmp_data
  always_comb
    state_d = (state == IDLE)     ? ((accept && cfg_ok) ? FEED : IDLE) :
              (state == FEED)     ? (last_sample ? DRAIN : FEED) :
              (state == DRAIN)    ? (rd_vld ? DRAIN : WAIT_RES) :
              (state == WAIT_RES) ? (result_ready ? WRITE : WAIT_RES) :
                                    (last_win ? IDLE : FEED);
  // state, job config latch and status flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      width_q <= '0;
      height_q <= '0;
      k_q <= '0;
      s_q <= '0;
      in_base_q <= '0;
      out_base_q <= '0;
      data_num <= '0;
      cfg_err <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      done <= (accept && !cfg_ok) || (wr_en && last_win);
      if (accept) cfg_err <= !cfg_ok;
      if (accept && cfg_ok) begin
        width_q <= fm_width;
        height_q <= fm_height;
        k_q <= pool_size;
        s_q <= pool_stride;
        in_base_q <= in_base;
        out_base_q <= out_base;
        data_num <= CLK_NUM_WIDTH'(kk);
      end else if (wr_en && last_win) data_num <= '0;
    end
  // read-data pipeline into the pool unit and result capture
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_vld <= 1'b0;
      cmp_data <= '0;
      res_q <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_vld) cmp_data <= rd_data;
      if (state == WAIT_RES && result_ready) res_q <= max_pool_result;
    end
  pool_window_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH)) u_addr (
    .clk(clk),
    .rst(rst),
    .init(accept && cfg_ok),
    .step(rd_en),
    .next_win(wr_en),
    .width(width_q),
    .height(height_q),
    .k(k_q),
    .s(s_q),
    .in_base(in_base_q),
    .out_base(out_base_q),
    .rd_addr(rd_addr),
    .wr_addr(wr_addr),
    .last_sample(last_sample),
    .last_win(last_win)
  );
endmodule

// File: tb/tb_max_pool_feeder.sv
// tb_max_pool_feeder: directed checks of the max-pool feeder against a memory and pool-unit model
module tb_max_pool_feeder;
  import max_pool_feeder_pkg::*;
  logic clk = 1'b0;
  logic rst, start, rd_en, wr_en, busy, done, cfg_err, result_ready;
  logic [7:0] fm_width, fm_height, pool_size, pool_stride, data_num;
  logic [11:0] in_base, out_base, rd_addr, wr_addr;
  logic [15:0] rd_data, cmp_data, max_pool_result, wr_data;
  logic [15:0] mem [4096];
  logic [15:0] vals [16];
  logic [15:0] t1_exp [4];
  logic [11:0] rd_q[$], wa_q[$];
  logic [15:0] wd_q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, s_cyc = 0, done_cyc = 0, n_done = 0;
  int p = -1, kk_cfg = 1, extra = 0;
  logic [15:0] mx, last_s;
  always #5 clk = ~clk;
  max_pool_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .fm_width(fm_width), .fm_height(fm_height), .pool_size(pool_size), .pool_stride(pool_stride),
    .in_base(in_base), .out_base(out_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmp_data(cmp_data), .data_num(data_num),
    .result_ready(result_ready), .max_pool_result(max_pool_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // pool unit model: takes K*K samples from 2 cycles after the first read, answers K*K+2 cycles after the first sample
  always @(negedge clk) begin
    result_ready = 1'b0;
    if (!rst) p = -1;
    else begin
      if (p < 0 && rd_en) p = 0;
      else if (p >= 0) p++;
      if (p >= 2 && p <= kk_cfg + 1) begin
        mx = (p == 2 || cmp_data > mx) ? cmp_data : mx;
        last_s = cmp_data;
      end
      if (p >= kk_cfg + 2 && p <= kk_cfg + 4 + extra) check("cmp_hold", cmp_data, last_s);
      if (p == kk_cfg + 4 + extra) begin
        result_ready = 1'b1;
        max_pool_result = mx;
        p = -1;
      end
    end
  end
  always @(negedge clk) if (rst) begin
    if (rd_en) rd_q.push_back(rd_addr);
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end
  task automatic start_job(input logic [7:0] w, h, k, s, input logic [11:0] ib, ob, input int ex);
    @(negedge clk);
    fm_width = w;
    fm_height = h;
    pool_size = k;
    pool_stride = s;
    in_base = ib;
    out_base = ob;
    kk_cfg = int'(k) * int'(k);
    extra = ex;
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    n_done = 0;
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("done_count", n_done, 1);
  endtask
  task automatic check_t1_writes(input string tag);
    check({tag, "_wr_cnt"}, wa_q.size(), 4);
    for (int i = 0; i < wa_q.size() && i < 4; i++) begin
      check({tag, "_wr_addr"}, wa_q[i], 12'h200 + 12'(i));
      check({tag, "_wr_data"}, wd_q[i], t1_exp[i]);
    end
  endtask
  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] bad [5][4];
    rst = 1'b0;
    start = 1'b0;
    fm_width = '0;
    fm_height = '0;
    pool_size = '0;
    pool_stride = '0;
    in_base = '0;
    out_base = '0;
    rd_data = '0;
    result_ready = 1'b0;
    max_pool_result = '0;
    vals = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800,
             16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};
    t1_exp = '{16'h4600, 16'h4800, 16'h4B00, 16'h4C00};
    bad = '{'{8'd4, 8'd4, 8'd5, 8'd2}, '{8'd4, 8'd4, 8'd2, 8'd0}, '{8'd4, 8'd4, 8'd0, 8'd1},
            '{8'd4, 8'd2, 8'd3, 8'd1}, '{8'd20, 8'd20, 8'd16, 8'd1}};
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem[12'h100 + i] = vals[i];
    mem[12'h300] = vals[2];
    mem[12'h301] = vals[6];
    mem[12'h302] = vals[0];
    mem[12'h303] = vals[8];
    mem[12'h304] = vals[1];
    mem[12'h305] = vals[7];
    mem[12'h306] = vals[3];
    mem[12'h307] = vals[5];
    mem[12'h308] = vals[4];
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_data_num", data_num, 0);
    check("rst_cmp_data", cmp_data, 0);
    rst = 1'b1;
    check("fp16_one_first", mem[12'h100], FP16_ONE);
    // 4x4, K=2, S=2
    start_job(8'd4, 8'd4, 8'd2, 8'd2, 12'h100, 12'h200, 0);
    check("t1_busy", busy, 1);
    check("t1_rd_en", rd_en, 1);
    check("t1_data_num", data_num, 4);
    check("t1_rd_addr0", rd_addr, 12'h100);
    wait_done(200);
    check("t1_done_cyc", done_cyc - s_cyc, 41);
    check("t1_rd_cnt", rd_q.size(), 16);
    if (rd_q.size() == 16) begin
      check("t1_rd_addr2", rd_q[2], 12'h104);
      check("t1_rd_addr4", rd_q[4], 12'h102);
      check("t1_rd_addr8", rd_q[8], 12'h108);
      check("t1_rd_addr15", rd_q[15], 12'h10F);
    end
    check_t1_writes("t1");
    // 3x3, K=3, S=1
    start_job(8'd3, 8'd3, 8'd3, 8'd1, 12'h300, 12'h380, 0);
    check("t2_data_num", data_num, 9);
    repeat (2) @(negedge clk);
    check("t2_first_cmp", cmp_data, 16'h4200);
    wait_done(100);
    check("t2_done_cyc", done_cyc - s_cyc, 16);
    check("t2_rd_cnt", rd_q.size(), 9);
    for (int i = 0; i < rd_q.size() && i < 9; i++) check("t2_rd_addr", rd_q[i], 12'h300 + 12'(i));
    check("t2_wr_cnt", wa_q.size(), 1);
    if (wa_q.size() > 0) begin
      check("t2_wr_addr", wa_q[0], 12'h380);
      check("t2_wr_data", wd_q[0], 16'h4880);
    end
    // invalid configurations
    for (int i = 0; i < 5; i++) begin
      start_job(bad[i][0], bad[i][1], bad[i][2], bad[i][3], 12'h100, 12'h200, 0);
      check("err_done", done, 1);
      check("err_cfg_err", cfg_err, 1);
      check("err_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("err_rd_cnt", rd_q.size(), 0);
      check("err_wr_cnt", wa_q.size(), 0);
      check("err_done_cnt", n_done, 1);
      check("err_sticky", cfg_err, 1);
    end
    // delayed result; next accepted start clears cfg_err
    start_job(8'd3, 8'd3, 8'd3, 8'd1, 12'h300, 12'h380, 10);
    check("t5_cfg_err_clr", cfg_err, 0);
    wait_done(100);
    extra = 0;
    check("t5_done_cyc", done_cyc - s_cyc, 26);
    check("t5_wr_cnt", wa_q.size(), 1);
    if (wd_q.size() > 0) check("t5_wr_data", wd_q[0], 16'h4880);
    // reset during FEED of the second window
    start_job(8'd4, 8'd4, 8'd2, 8'd2, 12'h100, 12'h200, 0);
    while (cyc < s_cyc + 12) @(negedge clk);
    check("t6_feeding", rd_en, 1);
    rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_rd_en", rd_en, 0);
    check("t6_wr_en", wr_en, 0);
    check("t6_done", done, 0);
    check("t6_cfg_err", cfg_err, 0);
    check("t6_data_num", data_num, 0);
    check("t6_cmp_data", cmp_data, 0);
    check("t6_wr_before", wa_q.size(), 1);
    @(negedge clk);
    rst = 1'b1;
    start_job(8'd4, 8'd4, 8'd2, 8'd2, 12'h100, 12'h200, 0);
    check("t6_restart_addr", rd_addr, 12'h100);
    wait_done(200);
    check_t1_writes("t6");
    // start while busy is ignored
    start_job(8'd4, 8'd4, 8'd2, 8'd2, 12'h100, 12'h200, 0);
    repeat (4) @(negedge clk);
    fm_width = 8'd3;
    fm_height = 8'd3;
    pool_size = 8'd3;
    pool_stride = 8'd1;
    in_base = 12'h300;
    out_base = 12'h380;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t7_data_num", data_num, 4);
    wait_done(200);
    check("t7_done_cyc", done_cyc - s_cyc, 41);
    check_t1_writes("t7");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
